// File: rtl/priority_index_decoder_pkg.sv
// Shared definitions for the 64-to-6 priority-encode path.
package pe_pkg;

  localparam int VEC_W = 64;
  localparam int IDX_W = $clog2(VEC_W);

  typedef enum logic {ACC, OUT} dec_state_t;

  typedef logic [IDX_W-1:0] idx_t;

endpackage

// File: rtl/priority_index_decoder_if.sv
// Index-beat input stream and rebuilt-frame output port of the decoder.
interface priority_index_decoder_if #(
  parameter int WIDTH = 64
) ();

  localparam int IDX_W = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] in_idx;
  logic             in_last;
  logic             in_empty;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_vec;
  logic [IDX_W:0]   out_count;
  logic             out_dup_err;
  logic             out_range_err;

  // Producer of index beats / consumer of rebuilt frames.
  modport master (
    output in_valid, in_idx, in_last, in_empty, out_ready,
    input  in_ready, out_valid, out_vec, out_count, out_dup_err, out_range_err
  );

  // The decoder itself.
  modport slave (
    input  in_valid, in_idx, in_last, in_empty, out_ready,
    output in_ready, out_valid, out_vec, out_count, out_dup_err, out_range_err
  );

endinterface

// File: rtl/priority_index_decoder_onehot.sv
// Combinational index-to-one-hot expansion; structural inverse of the encoder.
module onehot_decoder #(
  parameter int WIDTH = 64,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [IDX_W-1:0] idx,
  output logic [WIDTH-1:0] onehot,
  output logic             in_range
);

  // Indices >= WIDTH yield an all-zero vector and a cleared range flag.
  always_comb begin
    in_range = (32'(idx) < WIDTH);
    onehot   = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      onehot[i] = (32'(idx) == i);
    end
  end

endmodule

// File: rtl/priority_index_decoder.sv
// Rebuilds a WIDTH-bit request vector from a stream of encoded indices and
// presents it, with population count and error flags, on a valid/ready port.
module priority_index_decoder #(
  parameter int WIDTH = pe_pkg::VEC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  priority_index_decoder_if.slave  bus
);

  import pe_pkg::*;

  localparam int IDX_W = $clog2(WIDTH);

  dec_state_t       state_q, state_d;

  logic [WIDTH-1:0] acc_q, acc_upd;
  logic [IDX_W:0]   cnt_q, cnt_upd;
  logic             dup_q, dup_upd;
  logic             rng_q, rng_upd;

  logic [WIDTH-1:0] vec_q;
  logic [IDX_W:0]   count_q;
  logic             valid_q;
  logic             dup_err_q;
  logic             rng_err_q;

  logic [WIDTH-1:0] onehot;
  logic             in_range;
  logic             in_ready;
  logic             beat;
  logic             frame_done;

  onehot_decoder #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_onehot (
    .idx      (bus.in_idx),
    .onehot   (onehot),
    .in_range (in_range)
  );

  // in_ready is gated by rst so it reads low during the reset cycle itself.
  assign in_ready   = (state_q == ACC) && !rst;
  assign beat       = bus.in_valid && in_ready;
  assign frame_done = beat && bus.in_last;

  // Fold the current beat into the accumulator view used by both the
  // accumulate path and the output load, so the last beat is included.
  always_comb begin
    acc_upd = acc_q;
    cnt_upd = cnt_q;
    dup_upd = dup_q;
    rng_upd = rng_q;
    if (beat && !bus.in_empty) begin
      if (!in_range) begin
        rng_upd = 1'b1;
      end else if ((acc_q & onehot) != '0) begin
        dup_upd = 1'b1;
      end else begin
        acc_upd = acc_q | onehot;
        cnt_upd = cnt_q + 1'b1;
      end
    end
  end

  // Next-state selection: leave ACC on the last beat, leave OUT on handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACC: if (frame_done) state_d = OUT;
      OUT: if (valid_q && bus.out_ready) state_d = ACC;
      default: state_d = ACC;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ACC;
    else     state_q <= state_d;
  end

  // Accumulator and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      dup_q     <= 1'b0;
      rng_q     <= 1'b0;
      vec_q     <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      dup_err_q <= 1'b0;
      rng_err_q <= 1'b0;
    end else if (state_q == ACC) begin
      if (frame_done) begin
        vec_q     <= acc_upd;
        count_q   <= cnt_upd;
        dup_err_q <= dup_upd;
        rng_err_q <= rng_upd;
        valid_q   <= 1'b1;
        acc_q     <= '0;
        cnt_q     <= '0;
        dup_q     <= 1'b0;
        rng_q     <= 1'b0;
      end else begin
        acc_q <= acc_upd;
        cnt_q <= cnt_upd;
        dup_q <= dup_upd;
        rng_q <= rng_upd;
      end
    end else if (valid_q && bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = valid_q;
  assign bus.out_vec       = vec_q;
  assign bus.out_count     = count_q;
  assign bus.out_dup_err   = dup_err_q;
  assign bus.out_range_err = rng_err_q;

endmodule

// File: tb/tb_priority_index_decoder.sv
// Directed self-checking bench for priority_index_decoder (WIDTH 64 and 40).
module tb_priority_index_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  priority_index_decoder_if #(.WIDTH(64)) b64 ();
  priority_index_decoder_if #(.WIDTH(40)) b40 ();

  priority_index_decoder #(.WIDTH(64)) dut64 (
    .clk (clk),
    .rst (rst),
    .bus (b64)
  );

  priority_index_decoder #(.WIDTH(40)) dut40 (
    .clk (clk),
    .rst (rst),
    .bus (b40)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    b64.in_valid = 1'b0; b64.in_idx = '0; b64.in_last = 1'b0; b64.in_empty = 1'b0;
    b40.in_valid = 1'b0; b40.in_idx = '0; b40.in_last = 1'b0; b40.in_empty = 1'b0;
  endtask

  // One accepted beat on the selected instance (0: WIDTH 64, 1: WIDTH 40).
  task automatic beat(input int d, input int idx, input bit last, input bit empty);
    if (d == 0) begin
      b64.in_valid = 1'b1; b64.in_idx = 6'(idx); b64.in_last = last; b64.in_empty = empty;
      check("in_ready64", 64'(b64.in_ready), 64'd1);
    end else begin
      b40.in_valid = 1'b1; b40.in_idx = 6'(idx); b40.in_last = last; b40.in_empty = empty;
      check("in_ready40", 64'(b40.in_ready), 64'd1);
    end
    step();
    idle_inputs();
  endtask

  task automatic expect64(input string tag, input logic [63:0] vec, input int cnt,
                          input bit dup, input bit rng);
    check({tag, "_valid"}, 64'(b64.out_valid), 64'd1);
    check({tag, "_vec"},   b64.out_vec, vec);
    check({tag, "_count"}, 64'(b64.out_count), 64'(cnt));
    check({tag, "_dup"},   64'(b64.out_dup_err), 64'(dup));
    check({tag, "_rng"},   64'(b64.out_range_err), 64'(rng));
  endtask

  task automatic handshake64(input string tag);
    b64.out_ready = 1'b1;
    step();
    b64.out_ready = 1'b0;
    check({tag, "_valid_drop"}, 64'(b64.out_valid), 64'd0);
    check({tag, "_ready_back"}, 64'(b64.in_ready), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    b64.out_ready = 1'b0;
    b40.out_ready = 1'b0;

    // Reset values
    rst = 1'b1;
    step();
    step();
    check("rst_in_ready", 64'(b64.in_ready), 64'd0);
    check("rst_valid",    64'(b64.out_valid), 64'd0);
    check("rst_vec",      b64.out_vec, 64'd0);
    check("rst_count",    64'(b64.out_count), 64'd0);
    check("rst_dup",      64'(b64.out_dup_err), 64'd0);
    check("rst_rng",      64'(b64.out_range_err), 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(b64.in_ready), 64'd1);

    // Single beat, top index
    beat(0, 63, 1'b1, 1'b0);
    expect64("t1", 64'h8000_0000_0000_0000, 1, 1'b0, 1'b0);
    check("t1_in_ready_low", 64'(b64.in_ready), 64'd0);
    handshake64("t1");
    check("t1_vec_kept", b64.out_vec, 64'h8000_0000_0000_0000);

    // Three beats, consumer always ready; in_ready low exactly one cycle
    b64.out_ready = 1'b1;
    beat(0, 5, 1'b0, 1'b0);
    beat(0, 2, 1'b0, 1'b0);
    b64.in_valid = 1'b1; b64.in_idx = 6'd63; b64.in_last = 1'b1;
    step();
    idle_inputs();
    expect64("t2", 64'h8000_0000_0000_0024, 3, 1'b0, 1'b0);
    check("t2_in_ready_low", 64'(b64.in_ready), 64'd0);
    step();
    check("t2_valid_drop", 64'(b64.out_valid), 64'd0);
    check("t2_in_ready_back", 64'(b64.in_ready), 64'd1);
    b64.out_ready = 1'b0;

    // Duplicate index
    beat(0, 7, 1'b0, 1'b0);
    beat(0, 7, 1'b0, 1'b0);
    beat(0, 9, 1'b1, 1'b0);
    expect64("t3", 64'h0000_0000_0000_0280, 2, 1'b1, 1'b0);
    handshake64("t3");

    // Empty frame
    beat(0, 0, 1'b1, 1'b1);
    expect64("t4", 64'd0, 0, 1'b0, 1'b0);
    handshake64("t4");

    // Backpressure: output held, input stalled, then next frame accepted
    beat(0, 10, 1'b1, 1'b0);
    b64.in_valid = 1'b1; b64.in_idx = 6'd1; b64.in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("t5_in_ready_low", 64'(b64.in_ready), 64'd0);
      check("t5_valid_held",   64'(b64.out_valid), 64'd1);
      check("t5_vec_held",     b64.out_vec, 64'h400);
      check("t5_count_held",   64'(b64.out_count), 64'd1);
      step();
    end
    b64.out_ready = 1'b1;
    step();
    b64.out_ready = 1'b0;
    check("t5_valid_drop", 64'(b64.out_valid), 64'd0);
    check("t5_in_ready_back", 64'(b64.in_ready), 64'd1);
    step();
    idle_inputs();
    expect64("t5b", 64'h2, 1, 1'b0, 1'b0);
    handshake64("t5b");

    // WIDTH=40: out-of-range index dropped and flagged
    beat(1, 45, 1'b0, 1'b0);
    beat(1, 3, 1'b1, 1'b0);
    check("t6_valid", 64'(b40.out_valid), 64'd1);
    check("t6_vec",   64'(b40.out_vec), 64'h8);
    check("t6_count", 64'(b40.out_count), 64'd1);
    check("t6_dup",   64'(b40.out_dup_err), 64'd0);
    check("t6_rng",   64'(b40.out_range_err), 64'd1);
    b40.out_ready = 1'b1;
    step();
    b40.out_ready = 1'b0;
    check("t6_valid_drop", 64'(b40.out_valid), 64'd0);

    // Reset mid-frame discards the partial frame
    beat(0, 1, 1'b0, 1'b0);
    beat(0, 2, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t7_no_valid", 64'(b64.out_valid), 64'd0);
    step();
    check("t7_still_no_valid", 64'(b64.out_valid), 64'd0);
    beat(0, 4, 1'b1, 1'b0);
    expect64("t7", 64'h10, 1, 1'b0, 1'b0);
    handshake64("t7");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/priority_index_decoder.md
Name: priority_index_decoder

Overview:
- Receive end of the 64-to-6 priority-encode path: rebuilds a WIDTH-bit request vector from a stream of encoded indices.
- Upstream sends one index per set bit, then marks the final beat of the frame.
- Block accumulates the beats, then presents the rebuilt vector, population count and error flags on a valid/ready output port.
- Sits between the encoder-side serialiser and consumers that need the full vector, such as the grant/mask logic.

Parameters:
- WIDTH, 64, number of vector bits; any value 2..64.
- IDX_W, $clog2(WIDTH), index width; derived, must not be overridden.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  index beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- in_idx  in  IDX_W  encoded bit position; ignored when in_empty=1.
- in_last  in  1  final beat of the frame.
- in_empty  in  1  beat carries no index (zero-bit frame); legal only with in_last=1.
- out_valid  out  1  rebuilt frame available.
- out_ready  in  1  consumer accepts the frame.
- out_vec  out  WIDTH  rebuilt vector.
- out_count  out  IDX_W+1  number of distinct bits set in out_vec.
- out_dup_err  out  1  an index repeated within the frame.
- out_range_err  out  1  an index was >= WIDTH (only possible when WIDTH is not a power of 2).

Behaviour:
- Reset values: in_ready=0 during the rst cycle and 1 from the first cycle after; out_valid=0; out_vec=0; out_count=0; both error flags 0.
- Accumulator (acc, cnt, dup, rng) also clears on reset. State resets to ACC.
- State ACC:
  - in_ready=1.
  - A beat is accepted when in_valid && in_ready.
  - Non-empty beat, idx<WIDTH, bit clear in acc: set acc[idx]; cnt+=1.
  - Non-empty beat, idx<WIDTH, bit already set: acc and cnt unchanged; dup<=1.
  - idx>=WIDTH: beat dropped; rng<=1.
  - Empty beat: contributes nothing.
  - Accepted beat with in_last=1: next cycle, load out_* from the updated acc/cnt/dup/rng (the last beat's effect is included), set out_valid=1, clear the accumulator, go to OUT.
  - Latency: out_valid rises exactly 1 cycle after the last beat is accepted.
- State OUT:
  - in_ready=0. out_* held stable while out_valid && !out_ready.
  - On out_valid && out_ready: out_valid<=0 next cycle; go to ACC.
  - out_vec/out_count keep their last value after the handshake; consumers must qualify them with out_valid.
  - Throughput: a k-beat frame takes at least k+1 cycles.
- in_valid=0 in ACC: hold the accumulator; no timeout.
- in_empty=1 with in_last=0: protocol violation; treated as an empty beat, no flag.
- Counter width: cnt saturates naturally at WIDTH because duplicates do not increment, so no overflow is possible with IDX_W+1 bits.
- Reset mid-frame or mid-OUT: partial frame discarded, out_valid dropped, no output for that frame.
- Ordering: index order within a frame is irrelevant (descending priority order from the encoder is typical).

Decomposition:
- Shared package pe_pkg:
  - localparam VEC_W=64 and IDX_W=$clog2(VEC_W).
  - typedef enum logic {ACC, OUT} dec_state_t.
  - typedef logic [IDX_W-1:0] idx_t.
- Sub-module onehot_decoder: combinational IDX_W-to-WIDTH one-hot plus in-range flag; it is the structural inverse of the encoder.
- The top-level module holds the FSM, accumulator and output registers.

Test Plan:
- Reset, then a single beat idx=0x3F, last=1 -> 1 cycle later out_valid=1, out_vec=0x8000_0000_0000_0000, out_count=64'd1 truncated to 7'd1, errors 0.
- Frame idx 5, 2, 63 (last on 63), out_ready=1 -> out_vec=0x8000_0000_0000_0024, out_count=3, in_ready low for exactly 1 cycle.
- Frame idx 7, 7, 9 (last) -> out_vec=0x0000_0000_0000_0280, out_count=2, out_dup_err=1.
- Single empty beat (in_empty=1, last=1) -> out_vec=0, out_count=0, out_valid=1 next cycle.
- out_ready held 0 for 5 cycles, then in_valid asserted with idx=1 -> in_ready=0 and out_* stable throughout; after the handshake, the next frame's idx=1 beat is accepted.
- WIDTH=40: beat idx=45 then idx=3 (last) -> out_vec=0x08, out_count=1, out_range_err=1.
- Separate check: rst asserted after 2 beats of a frame -> no out_valid; a following frame with idx=4 (last) yields out_vec=0x10 only.
